// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit field layout, port indices, flit types and
// the XY route function also used by the router's route-compute stage.
package noc_pkg;

  localparam int X_SIZE     = 4;
  localparam int Y_SIZE     = 4;
  localparam int X_W        = $clog2(X_SIZE);
  localparam int Y_W        = $clog2(Y_SIZE);
  localparam int VC_NUM     = 5;
  localparam int DATA_WIDTH = 64;
  localparam int FLIT_WIDTH = 80;
  localparam int MAX_LEN    = 16;
  localparam int LEN_W      = $clog2(MAX_LEN + 1);
  localparam int PORT_NUM   = 5;

  localparam int XP    = 0;
  localparam int XM    = 1;
  localparam int YM    = 2;
  localparam int YP    = 3;
  localparam int LOCAL = 4;

  localparam int TYPE_LSB = 0;
  localparam int HOP_LSB  = 2;
  localparam int DSTX_LSB = 7;
  localparam int DSTY_LSB = 9;
  localparam int VC_LSB   = 11;
  localparam int DATA_LSB = 16;

  typedef enum logic [1:0] {
    FLIT_IDLE = 2'b00,
    FLIT_HEAD = 2'b01,
    FLIT_BODY = 2'b10,
    FLIT_TAIL = 2'b11
  } flit_type_e;

  // Dimension-ordered routing: resolve X first, then Y, then eject locally.
  function automatic logic [PORT_NUM-1:0] xy_route(input logic [X_W-1:0] dst_x,
                                                   input logic [Y_W-1:0] dst_y,
                                                   input logic [X_W-1:0] cur_x,
                                                   input logic [Y_W-1:0] cur_y);
    logic [PORT_NUM-1:0] hop;
    hop = '0;
    if (dst_x > cur_x) begin
      hop[XP] = 1'b1;
    end else if (dst_x < cur_x) begin
      hop[XM] = 1'b1;
    end else if (dst_y < cur_y) begin
      hop[YM] = 1'b1;
    end else if (dst_y > cur_y) begin
      hop[YP] = 1'b1;
    end else begin
      hop[LOCAL] = 1'b1;
    end
    return hop;
  endfunction

  function automatic logic [FLIT_WIDTH-1:0] make_flit(input flit_type_e t,
                                                      input logic [PORT_NUM-1:0] hop,
                                                      input logic [X_W-1:0] dx,
                                                      input logic [Y_W-1:0] dy,
                                                      input logic [VC_NUM-1:0] vc,
                                                      input logic [DATA_WIDTH-1:0] data);
    logic [FLIT_WIDTH-1:0] f;
    f = '0;
    f[TYPE_LSB +: 2]          = t;
    f[HOP_LSB  +: PORT_NUM]   = hop;
    f[DSTX_LSB +: X_W]        = dx;
    f[DSTY_LSB +: Y_W]        = dy;
    f[VC_LSB   +: VC_NUM]     = vc;
    f[DATA_LSB +: DATA_WIDTH] = data;
    return f;
  endfunction

endpackage

// File: rtl/rr_vc_select.sv
// Round-robin picker of a free virtual channel; the pointer only moves when
// the caller actually takes the grant.
module rr_vc_select
  import noc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [VC_NUM-1:0] busy,
  input  logic              advance,
  output logic [VC_NUM-1:0] grant,
  output logic              valid
);

  localparam int PTR_W = $clog2(VC_NUM);

  logic [PTR_W-1:0] ptr_r;
  logic [PTR_W-1:0] sel_s;
  logic [PTR_W-1:0] idx_s;
  logic [PTR_W:0]   sum_s;
  logic [PTR_W-1:0] nxt_ptr_s;

  // First non-busy VC at or above the pointer, wrapping past VC_NUM-1.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    sel_s = '0;
    sum_s = '0;
    idx_s = '0;
    for (int i = 0; i < VC_NUM; i++) begin
      sum_s = {1'b0, ptr_r} + (PTR_W + 1)'(i);
      if (sum_s >= (PTR_W + 1)'(VC_NUM)) begin
        sum_s = sum_s - (PTR_W + 1)'(VC_NUM);
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[PTR_W-1:0];
      if (!valid && !busy[idx_s]) begin
        valid        = 1'b1;
        grant[idx_s] = 1'b1;
        sel_s        = idx_s;
      end else begin
        valid = valid;
      end
    end
  end

  assign nxt_ptr_s = (sel_s == PTR_W'(VC_NUM - 1)) ? '0 : sel_s + PTR_W'(1);

  // Pointer register: restart just past the VC that was granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (advance && valid) begin
      ptr_r <= nxt_ptr_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/ni_packetizer.sv
// NI transmit side: wraps a header plus payload words into a wormhole packet
// of head/body/tail flits on one round-robin-chosen VC of the local port.
module ni_packetizer
  import noc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [X_W-1:0]        id_x,
  input  logic [Y_W-1:0]        id_y,
  input  logic                  msg_valid,
  output logic                  msg_ready,
  input  logic [1:0]            msg_dst_x,
  input  logic [1:0]            msg_dst_y,
  input  logic [LEN_W-1:0]      msg_len,
  input  logic                  pay_valid,
  output logic                  pay_ready,
  input  logic [DATA_WIDTH-1:0] pay_data,
  input  logic [VC_NUM-1:0]     vc_busy_in,
  output logic [FLIT_WIDTH-1:0] flit_out,
  output logic                  pkt_done,
  output logic                  err_len
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ALLOC = 2'b01,
    S_SEND  = 2'b10
  } state_e;

  state_e                state_r, state_n;
  logic [X_W-1:0]        dst_x_r;
  logic [Y_W-1:0]        dst_y_r;
  logic [LEN_W-1:0]      len_r, rem_r;
  logic [PORT_NUM-1:0]   hop_r;
  logic [VC_NUM-1:0]     cur_vc_r, vc_grant_s;
  logic                  vc_valid_s, advance_s;
  logic                  msg_hs_s, pay_hs_s, len_bad_s;
  logic [DATA_WIDTH-1:0] head_data_s;
  logic [FLIT_WIDTH-1:0] flit_n;
  logic                  pkt_done_n, err_len_n;

  rr_vc_select u_vc_sel (
    .clk     (clk),
    .rst     (rst),
    .busy    (vc_busy_in),
    .advance (advance_s),
    .grant   (vc_grant_s),
    .valid   (vc_valid_s)
  );

  // Ready flags; a payload word may only move while the held VC can take it.
  always_comb begin
    msg_ready = 1'b0;
    pay_ready = 1'b0;
    if (!rst && state_r == S_IDLE) begin
      msg_ready = 1'b1;
    end else begin
      msg_ready = 1'b0;
    end
    if (!rst && state_r == S_SEND) begin
      pay_ready = ~|(vc_busy_in & cur_vc_r);
    end else begin
      pay_ready = 1'b0;
    end
  end

  assign msg_hs_s  = msg_valid && msg_ready;
  assign pay_hs_s  = pay_valid && pay_ready;
  assign len_bad_s = (msg_len == '0) || (msg_len > LEN_W'(MAX_LEN));

  // Next state and the flit/pulses to register on this edge.
  always_comb begin
    state_n     = state_r;
    flit_n      = '0;
    pkt_done_n  = 1'b0;
    err_len_n   = 1'b0;
    advance_s   = 1'b0;
    head_data_s = '0;
    head_data_s[7:0]   = 8'(len_r);
    head_data_s[9:8]   = id_x;
    head_data_s[11:10] = id_y;
    case (state_r)
      S_IDLE: begin
        if (msg_hs_s && len_bad_s) begin
          err_len_n = 1'b1;
        end else if (msg_hs_s) begin
          state_n = S_ALLOC;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_ALLOC: begin
        if (vc_valid_s) begin
          advance_s = 1'b1;
          state_n   = S_SEND;
          flit_n    = make_flit(FLIT_HEAD, hop_r, dst_x_r, dst_y_r, vc_grant_s, head_data_s);
        end else begin
          state_n = S_ALLOC;
        end
      end
      S_SEND: begin
        if (pay_hs_s && rem_r == LEN_W'(1)) begin
          flit_n     = make_flit(FLIT_TAIL, hop_r, dst_x_r, dst_y_r, cur_vc_r, pay_data);
          pkt_done_n = 1'b1;
          state_n    = S_IDLE;
        end else if (pay_hs_s) begin
          flit_n = make_flit(FLIT_BODY, hop_r, dst_x_r, dst_y_r, cur_vc_r, pay_data);
        end else begin
          state_n = S_SEND;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State, registered outputs and per-packet context.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_IDLE;
      flit_out <= '0;
      pkt_done <= 1'b0;
      err_len  <= 1'b0;
      dst_x_r  <= '0;
      dst_y_r  <= '0;
      len_r    <= '0;
      rem_r    <= '0;
      hop_r    <= '0;
      cur_vc_r <= '0;
    end else begin
      state_r  <= state_n;
      flit_out <= flit_n;
      pkt_done <= pkt_done_n;
      err_len  <= err_len_n;
      if (msg_hs_s && !len_bad_s) begin
        dst_x_r <= msg_dst_x;
        dst_y_r <= msg_dst_y;
        len_r   <= msg_len;
        rem_r   <= msg_len;
        hop_r   <= xy_route(msg_dst_x, msg_dst_y, id_x, id_y);
      end else if (advance_s) begin
        cur_vc_r <= vc_grant_s;
      end else if (pay_hs_s) begin
        rem_r <= rem_r - LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ni_packetizer.sv
// Random traffic against a transaction-level reference of the packetizer:
// messages, payload queue, round-robin VC choice and busy back-pressure.
module tb_ni_packetizer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  id_x, id_y;
  logic        msg_valid, msg_ready;
  logic [1:0]  msg_dst_x, msg_dst_y;
  logic [4:0]  msg_len;
  logic        pay_valid, pay_ready;
  logic [63:0] pay_data;
  logic [4:0]  vc_busy_in;
  logic [79:0] flit_out;
  logic        pkt_done, err_len;

  always #5 clk = ~clk;

  ni_packetizer dut (
    .clk(clk), .rst(rst), .id_x(id_x), .id_y(id_y),
    .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_dst_x(msg_dst_x), .msg_dst_y(msg_dst_y), .msg_len(msg_len),
    .pay_valid(pay_valid), .pay_ready(pay_ready), .pay_data(pay_data),
    .vc_busy_in(vc_busy_in), .flit_out(flit_out),
    .pkt_done(pkt_done), .err_len(err_len)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference state: 0 waiting for a message, 1 waiting for a VC, 2 sending.
  int          m_mode = 0;
  int          m_rr = 0, m_vc = 0, m_rem = 0, m_len = 0, m_dx = 0, m_dy = 0, m_hop = 0;
  logic [63:0] pay_q[$];
  logic [63:0] hdr_words[$];
  logic [79:0] exp_flit;
  logic        exp_done, exp_err, hdr_taken;
  int          hdr_pend = 0, rst_cnt = 2, busy_hold = 0;
  int          n_pkts = 0, n_errs = 0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic int route_ref(input int dx, input int dy, input int ix, input int iy);
    if (dx > ix) return 0;
    if (dx < ix) return 1;
    if (dy < iy) return 2;
    if (dy > iy) return 3;
    return 4;
  endfunction

  function automatic logic [79:0] ref_flit(input int typ, input int hop, input int dx,
                                           input int dy, input int vc, input logic [63:0] data);
    logic [79:0] f;
    f = {data, 16'h0000};
    f = f | 80'(typ) | (80'(1) << (2 + hop)) | (80'(dx) << 7) | (80'(dy) << 9)
          | (80'(1) << (11 + vc));
    return f;
  endfunction

  // Apply the edge about to happen to the reference, using the current inputs.
  task automatic model_edge();
    int          pick;
    int          v;
    logic [63:0] w;
    logic [63:0] hd;
    exp_flit  = '0;
    exp_done  = 1'b0;
    exp_err   = 1'b0;
    hdr_taken = 1'b0;
    pick      = -1;
    if (rst) begin
      m_mode = 0;
      m_rr   = 0;
      pay_q.delete();
    end else if (m_mode == 0) begin
      if (msg_valid) begin
        hdr_taken = 1'b1;
        if (msg_len == 5'd0 || msg_len > 5'd16) begin
          exp_err = 1'b1;
          n_errs++;
        end else begin
          m_mode = 1;
          m_len  = int'(msg_len);
          m_dx   = int'(msg_dst_x);
          m_dy   = int'(msg_dst_y);
          m_hop  = route_ref(m_dx, m_dy, int'(id_x), int'(id_y));
          pay_q  = hdr_words;
        end
      end
    end else if (m_mode == 1) begin
      for (int k = 0; k < 5; k++) begin
        v = (m_rr + k) % 5;
        if (pick < 0 && !vc_busy_in[v]) pick = v;
      end
      if (pick >= 0) begin
        m_vc   = pick;
        m_rr   = (pick + 1) % 5;
        m_rem  = m_len;
        m_mode = 2;
        hd = 64'(m_len) | (64'(id_x) << 8) | (64'(id_y) << 10);
        exp_flit = ref_flit(1, m_hop, m_dx, m_dy, m_vc, hd);
      end
    end else begin
      if (pay_valid && !vc_busy_in[m_vc]) begin
        w = pay_q.pop_front();
        m_rem--;
        if (m_rem == 0) begin
          exp_flit = ref_flit(3, m_hop, m_dx, m_dy, m_vc, w);
          exp_done = 1'b1;
          m_mode   = 0;
          n_pkts++;
        end else begin
          exp_flit = ref_flit(2, m_hop, m_dx, m_dy, m_vc, w);
        end
      end
    end
  endtask

  // Choose the inputs for the next edge.
  task automatic drive();
    int r;
    if (rst_cnt > 0) begin
      rst = 1'b1;
      rst_cnt--;
    end else if ($urandom_range(0, 299) == 0) begin
      rst     = 1'b1;
      rst_cnt = $urandom_range(0, 1);
      id_x    = 2'($urandom_range(0, 3));
      id_y    = 2'($urandom_range(0, 3));
    end else begin
      rst = 1'b0;
    end

    if (hdr_taken) begin
      msg_valid = 1'b0;
      hdr_pend  = 0;
    end
    if (hdr_pend == 0) begin
      msg_dst_x = 2'($urandom);
      msg_dst_y = 2'($urandom);
      msg_len   = 5'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 9);
        if (r == 0) msg_len = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(17, 31));
        else if (r == 1) msg_len = 5'($urandom_range(1, 16));
        else msg_len = 5'($urandom_range(1, 4));
        hdr_words.delete();
        for (int i = 0; i < int'(msg_len); i++) hdr_words.push_back({$urandom, $urandom});
        msg_valid = 1'b1;
        hdr_pend  = 1;
      end
    end

    if (pay_q.size() > 0 && $urandom_range(0, 3) != 0) begin
      pay_valid = 1'b1;
      pay_data  = pay_q[0];
    end else begin
      pay_valid = 1'b0;
      pay_data  = {$urandom, $urandom};
    end

    if (busy_hold > 0) begin
      vc_busy_in = 5'b11111;
      busy_hold--;
    end else if ($urandom_range(0, 39) == 0) begin
      vc_busy_in = 5'b11111;
      busy_hold  = $urandom_range(1, 6);
    end else begin
      vc_busy_in = 5'($urandom) & 5'($urandom);
    end
  endtask

  initial begin
    rst        = 1'b1;
    id_x       = 2'd1;
    id_y       = 2'd1;
    msg_valid  = 1'b0;
    msg_dst_x  = 2'd0;
    msg_dst_y  = 2'd0;
    msg_len    = 5'd0;
    pay_valid  = 1'b0;
    pay_data   = 64'd0;
    vc_busy_in = 5'b00000;
    @(negedge clk);
    #1;
    for (cyc = 0; cyc < 5000; cyc++) begin
      check("msg_ready", 80'(msg_ready), 80'(!rst && m_mode == 0));
      check("pay_ready", 80'(pay_ready), 80'(!rst && m_mode == 2 && !vc_busy_in[m_vc]));
      model_edge();
      @(posedge clk);
      @(negedge clk);
      check("flit_out", flit_out, exp_flit);
      check("pkt_done", 80'(pkt_done), 80'(exp_done));
      check("err_len", 80'(err_len), 80'(exp_err));
      drive();
      #1;
    end
    check("packets_seen", 80'(n_pkts > 50), 80'(1));
    check("len_errors_seen", 80'(n_errs > 5), 80'(1));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ni_packetizer.md
Name: ni_packetizer

Overview:
- Network-interface transmit side: turns a local message (destination plus N 64-bit payload words) into a wormhole packet of 80-bit flits.
- Drives the router's local input port.
- Selects a free virtual channel (VC) from the router's per-VC busy flags, round-robin, and holds it for the whole packet.
- Stalls flit emission while the held VC is busy.

Parameters:
- x_size, 4: mesh columns.
- y_size, 4: mesh rows.
- VC_NUM, 5: virtual channels per port; VCx field is one-hot.
- DATA_WIDTH, 64: payload word width.
- FLIT_WIDTH, 80: flit width.
- MAX_LEN, 16: maximum payload words per packet; LEN_W = $clog2(MAX_LEN+1).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_x  in  $clog2(x_size)  own node X.
- id_y  in  $clog2(y_size)  own node Y.
- msg_valid  in  1  message header valid.
- msg_ready  out  1  header accepted on valid&&ready.
- msg_dst_x  in  2  destination X.
- msg_dst_y  in  2  destination Y.
- msg_len  in  LEN_W  payload word count.
- pay_valid  in  1  payload word valid.
- pay_ready  out  1  payload word accepted on valid&&ready.
- pay_data  in  DATA_WIDTH  payload word.
- vc_busy_in  in  VC_NUM  router local-port VC busy flags; 1 = cannot accept a flit this cycle.
- flit_out  out  FLIT_WIDTH  registered flit to router local_in.
- pkt_done  out  1  registered one-cycle pulse, coincident with the tail flit.
- err_len  out  1  registered one-cycle pulse when a header with illegal length is dropped.

Behaviour:
- Flit layout:
  - [1:0] type: 00 idle, 01 head, 10 body, 11 tail.
  - [6:2] nxt_hop, one-hot.
  - [8:7] dst_x.
  - [10:9] dst_y.
  - [15:11] VCx, one-hot.
  - [79:16] data.
- Idle flit is all zeros.
- nxt_hop is computed once per packet with XY routing, port order bit0 X+, bit1 X-, bit2 Y-, bit3 Y+, bit4 local:
  - dst_x>id_x gives X+; dst_x<id_x gives X-.
  - Otherwise dst_y<id_y gives Y-; dst_y>id_y gives Y+.
  - Otherwise local.
- nxt_hop, dst and VCx are identical in every flit of a packet.
- Head data: [7:0] msg_len zero-extended, [9:8] id_x, [11:10] id_y, rest 0.
- Body and tail data carry payload words in arrival order. The last word rides in the tail flit.
- A packet of L words is one head, L-1 bodies and one tail.
- Reset: state IDLE, flit_out=0, pkt_done=0, err_len=0, rr pointer=0. msg_ready=0 and pay_ready=0 while rst=1.
- FSM:
  - IDLE:
    - msg_ready=1.
    - On handshake, latch dst and len.
    - If len==0 or len>MAX_LEN: pulse err_len next cycle, stay IDLE.
    - Else go to ALLOC.
  - ALLOC:
    - msg_ready=0, pay_ready=0.
    - If any vc_busy_in bit is 0, pick the first free VC searching from the rr pointer upward with wrap.
    - Latch it, register the head flit, set rr pointer to (chosen+1) mod VC_NUM, go to SEND.
    - If all VCs are busy, hold state and emit idle.
  - SEND:
    - pay_ready = !vc_busy_in[cur_vc].
    - On handshake, register a body flit, or a tail flit when remaining==1, and decrement remaining.
    - On the tail: pulse pkt_done and go to IDLE.
    - Cycles without a handshake emit idle.
- Latency:
  - Header accepted at edge 0; head flit visible after edge 1 if a VC is free.
  - Word k is visible after its handshake edge.
  - With no stalls, back-to-back L-word packets issue every L+2 cycles.
- Simultaneous events:
  - A header presented on the tail cycle is not accepted (msg_ready=0); it is accepted next cycle.
  - vc_busy_in is sampled in the same cycle as the emitting edge.
- Reset mid-packet: abort; flit_out=0 from the next cycle; no tail is sent. The router shares rst.

Decomposition:
- noc_pkg holds:
  - flit_type_e (IDLE/HEAD/BODY/TAIL).
  - Field bit-position constants.
  - Port index constants (XP=0, XM=1, YM=2, YP=3, LOCAL=4).
  - An XY-route function shared with rc.
- One sub-module, rr_vc_select: pointer register, busy vector in, one-hot grant plus valid out, and an advance input.

Test Plan:
- id=(1,1); dst=(3,1), len=3, words A,B,C; VCs all free → head with nxt_hop=00001, VCx=00001, data[7:0]=3, then body A, body B, tail C; pkt_done with the tail.
- Two packets back-to-back, len=1 each, dst=(1,1) → head/tail pairs with nxt_hop=10000; VCx 00001 then 00010 (round-robin); second head 3 cycles after first.
- vc_busy_in=11111 for 4 cycles after header, then 11011 → 4 idle flits, then head with VCx=00100.
- len=4; set the held VC busy for 2 cycles after body 1 → pay_ready=0, two idle flits, then bodies and tail resume with data order intact.
- msg_len=0, then msg_len=17 → err_len pulses, no flits, msg_ready stays 1.
- rst asserted after body 1 of len=5 → flit_out=0 next cycle, msg_ready=1 one cycle after rst drops, rr pointer back to 0.
